// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshake, response and ALU datapath signals for alu_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if;
  logic        req_valid_a;
  logic        req_valid_b;
  logic [4:0]  req_opcode_a;
  logic [4:0]  req_opcode_b;
  logic [31:0] req_op1_a;
  logic [31:0] req_op1_b;
  logic [31:0] req_op2_a;
  logic [31:0] req_op2_b;
  logic        req_ready_a;
  logic        req_ready_b;
  logic        resp_valid_a;
  logic        resp_valid_b;
  logic [31:0] resp_data;
  logic        resp_ovf;
  logic        resp_err;
  logic [5:0]  alu_command;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        alu_ovf;

  modport master (
    output req_valid_a, req_valid_b, req_opcode_a, req_opcode_b,
    output req_op1_a, req_op1_b, req_op2_a, req_op2_b,
    output alu_result, alu_ovf,
    input  req_ready_a, req_ready_b, resp_valid_a, resp_valid_b,
    input  resp_data, resp_ovf, resp_err, alu_command, alu_op1, alu_op2
  );

  modport slave (
    input  req_valid_a, req_valid_b, req_opcode_a, req_opcode_b,
    input  req_op1_a, req_op1_b, req_op2_a, req_op2_b,
    input  alu_result, alu_ovf,
    output req_ready_a, req_ready_b, resp_valid_a, resp_valid_b,
    output resp_data, resp_ovf, resp_err, alu_command, alu_op1, alu_op2
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational 32-bit ALU between requesters A and B.
// One operation in flight: IDLE accepts, ISSUE drives the ALU, RESP returns a one-cycle pulse.
module alu_arbiter (
  input  logic         clock,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      r_state;
  logic        r_last_grant_b;
  logic        r_grant_b;
  logic [5:0]  r_alu_command;
  logic [31:0] r_alu_op1;
  logic [31:0] r_alu_op2;
  logic [31:0] r_resp_data;
  logic        r_resp_ovf;
  logic        r_resp_err;
  logic        r_resp_valid_a;
  logic        r_resp_valid_b;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_ready_a;
  logic        w_ready_b;
  logic        w_accept;
  logic [4:0]  w_opcode;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_opcode_ok;
  logic [5:0]  w_command;

  // On a tie the requester not granted most recently wins.
  always_comb begin
    w_grant_a   = bus.req_valid_a & (~bus.req_valid_b | r_last_grant_b);
    w_grant_b   = bus.req_valid_b & ~w_grant_a;
    w_ready_a   = reset_n & (r_state == StIdle) & w_grant_a;
    w_ready_b   = reset_n & (r_state == StIdle) & w_grant_b;
    w_accept    = w_ready_a | w_ready_b;
    w_opcode    = w_grant_b ? bus.req_opcode_b : bus.req_opcode_a;
    w_op1       = w_grant_b ? bus.req_op1_b : bus.req_op1_a;
    w_op2       = w_grant_b ? bus.req_op2_b : bus.req_op2_a;
    w_opcode_ok = (w_opcode <= 5'd5);
    w_command   = 6'b000001 << w_opcode[2:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_last_grant_b <= 1'b1;
      r_grant_b      <= 1'b0;
      r_alu_command  <= '0;
      r_alu_op1      <= '0;
      r_alu_op2      <= '0;
      r_resp_data    <= '0;
      r_resp_ovf     <= 1'b0;
      r_resp_err     <= 1'b0;
      r_resp_valid_a <= 1'b0;
      r_resp_valid_b <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_alu_op1      <= w_op1;
            r_alu_op2      <= w_op2;
            r_grant_b      <= w_grant_b;
            r_last_grant_b <= w_grant_b;
            if (w_opcode_ok) begin
              r_alu_command <= w_command;
              r_state       <= StIssue;
            end else begin
              // Unsupported opcode bypasses the ALU and responds straight away.
              r_resp_data    <= '0;
              r_resp_ovf     <= 1'b0;
              r_resp_err     <= 1'b1;
              r_resp_valid_a <= ~w_grant_b;
              r_resp_valid_b <= w_grant_b;
              r_state        <= StResp;
            end
          end
        end
        StIssue: begin
          r_alu_command  <= '0;
          r_resp_data    <= bus.alu_result;
          r_resp_ovf     <= bus.alu_ovf;
          r_resp_err     <= 1'b0;
          r_resp_valid_a <= ~r_grant_b;
          r_resp_valid_b <= r_grant_b;
          r_state        <= StResp;
        end
        StResp: begin
          r_resp_valid_a <= 1'b0;
          r_resp_valid_b <= 1'b0;
          r_state        <= StIdle;
        end
        default: begin
          r_alu_command  <= '0;
          r_resp_valid_a <= 1'b0;
          r_resp_valid_b <= 1'b0;
          r_state        <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready_a  = w_ready_a;
  assign bus.req_ready_b  = w_ready_b;
  assign bus.resp_valid_a = r_resp_valid_a;
  assign bus.resp_valid_b = r_resp_valid_b;
  assign bus.resp_data    = r_resp_data;
  assign bus.resp_ovf     = r_resp_ovf;
  assign bus.resp_err     = r_resp_err;
  assign bus.alu_command  = r_alu_command;
  assign bus.alu_op1      = r_alu_op1;
  assign bus.alu_op2      = r_alu_op2;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and round-robin arbiter that shares the single-cycle 32-bit ALU datapath between two requesters, A and B. It accepts one operation at a time through a valid/ready handshake and decodes the 5-bit opcode into the ALU's 6-bit one-hot command. It drives registered operands and command into the ALU, captures the result and overflow, and returns them to the winning requester with a one-cycle response pulse. It sits between the instruction-issue logic and the combinational ALU/mux datapath.

## Interface
- No parameters; data width is fixed at 32 bits, the opcode at 5 bits and the command at 6 bits.
- clock  in  1  system clock, rising-edge active.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid_a, req_valid_b  in  1  request present from requester A / B.
- req_opcode_a, req_opcode_b  in  5  ALU opcode.
- req_op1_a, req_op1_b, req_op2_a, req_op2_b  in  32  operands.
- req_ready_a, req_ready_b  out  1  request accepted this cycle.
- resp_valid_a, resp_valid_b  out  1  one-cycle response pulse.
- resp_data  out  32  result, shared by both requesters and qualified by resp_valid_*.
- resp_ovf  out  1  overflow captured from the ALU.
- resp_err  out  1  unsupported-opcode flag.
- alu_command  out  6  one-hot command to the ALU. Bit 0 is ADD, bit 1 is SUB, bit 2 is AND, bit 3 is OR, bit 4 is SLL, bit 5 is SRA.
- alu_op1, alu_op2  out  32  registered ALU operands.
- alu_result  in  32  combinational ALU result.
- alu_ovf  in  1  combinational ALU overflow.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. The reset state is IDLE.
- **IDLE:**
  - Arbitrate between the requesters. If only one req_valid is high, that requester wins.
  - If both are high, the requester not granted most recently wins.
  - The last_grant register resets to B, so A wins the first tie.
  - req_ready_x is combinational and equals (state == IDLE) AND grant_x. At most one ready is high.
  - On the edge where valid and ready are both high:
    - latch the opcode and operands;
    - update last_grant;
    - go to ISSUE if the opcode is 0–5, otherwise go to RESP with the error flag set.
- **ISSUE (exactly 1 cycle):**
  - alu_command = 1 << opcode. alu_op1 and alu_op2 hold the latched operands.
  - At the closing edge, register alu_result into resp_data and alu_ovf into resp_ovf, then go to RESP.
- **RESP (exactly 1 cycle):**
  - Assert resp_valid of the granted requester with resp_data, resp_ovf and resp_err valid.
  - Return to IDLE.
- **Error path:** resp_data = 0, resp_ovf = 0, resp_err = 1. The ALU is never issued, so alu_command stays 0.
- **alu_command** is 6'b000000 in every state except ISSUE. alu_op1 and alu_op2 hold their last latched value.
- **No back-pressure on responses.** A requester must take the response during the RESP cycle.
- **One outstanding operation in total.** No request is accepted during ISSUE or RESP. Requests held high wait in IDLE.
- **Requester obligation:** hold valid, opcode and operands stable until ready is seen. The block never drops an accepted request.
- **Reset (asynchronous, takes effect immediately, including mid-operation):**
  - State returns to IDLE and the in-flight operation is discarded with no response.
  - All registered outputs go to 0: alu_command, alu_op1, alu_op2, resp_data, resp_ovf, resp_err and both resp_valid.
  - last_grant returns to B.
  - req_ready_* are 0 while reset_n is low.

## Timing
- Define edge N as the rising edge that sees req_valid_x and req_ready_x both high.
- **Normal latency:**
  - Cycle N→N+1: ISSUE, with alu_command, alu_op1 and alu_op2 valid.
  - Cycle N+1→N+2: RESP, with resp_valid_x high.
  - Cycle N+2 onward: IDLE again, and a new acceptance is possible at edge N+3.
  - Peak throughput is one operation per 3 cycles.
- **Error latency:** RESP occupies cycle N→N+1, and a new acceptance is possible at edge N+2.
- **Combinational ALU constraint:** the ALU must settle within one cycle. alu_result is sampled only at the edge that closes ISSUE.
- **Tie handling:** with both requesters continuously valid, grants alternate A, B, A, B.
- **Late arrival:** a request arriving during ISSUE or RESP is served starting in the first IDLE cycle.

## Test plan
- **Reset:** hold reset_n low → all outputs are 0. Release reset, with A raising ADD 5 + 7 one cycle later → req_ready_a is high the same cycle; alu_command = 000001 during ISSUE; resp_valid_a is high 2 cycles after acceptance with resp_data = 12 and resp_ovf = 0.
- **Overflow:** B sends SUB 0x80000000 − 1 → alu_command = 000010; resp_data = 0x7FFFFFFF; resp_ovf = 1; resp_valid_b pulses once.
- **Contention:** A and B both valid continuously for 4 operations → grant order A, B, A, B; accept edges spaced 3 cycles apart; every response goes to the correct requester.
- **Illegal opcode:** A sends opcode 6 (then 31) → alu_command never leaves 0; resp_valid_a is high on the cycle after acceptance with resp_err = 1 and resp_data = 0; the next request is accepted one cycle later.
- **Reset during ISSUE:** drop reset_n while in ISSUE → outputs clear immediately; no resp_valid is ever seen for that operation; the next grant after release goes to A.
- **Late arrival:** B raises a request while A's operation is in RESP → req_ready_b goes high in the first IDLE cycle, not before.
